mc_mem_responder: RTL and testbench

- Unified instruction/data memory responder for the multicycle RISC-V core.
- Accepts one fetch, load or store request at a time from the core's control and datapath side.
- Inserts a programmable number of wait states, then returns read data or a store completion, so the controller can stall on real memory latency.
- Performs RV32I sub-word load extension (LB/LH/LW/LBU/LHU) and byte-lane stores (SB/SH/SW).

---
 rtl/mc_mem_responder_if.sv | 25 ++
 rtl/mc_mem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_mc_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if: request/response bundle between the multicycle core and its memory responder.
//   master (core side) drives:      req_valid, req_write, req_func3, req_addr, req_wdata
//   slave (responder side) drives:  req_ready, resp_valid, resp_rdata, resp_err, busy
interface mc_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: unified instruction/data memory for the multicycle RISC-V core.
// Accepts one fetch/load/store at a time, waits LATENCY cycles, then pulses a response
// carrying RV32I-extended load data or a store completion.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset (memory contents are retained)
//   bus    - mc_mem_responder_if.slave: req_valid/req_ready/req_write/req_func3/req_addr/
//            req_wdata in, resp_valid/resp_rdata/resp_err/busy out
// Parameters:
//   DEPTH_WORDS - 32-bit words in the array (power of two, >= 2)
//   LATENCY     - wait cycles between acceptance and response (0..15)
module mc_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic               clk,
    input logic               reset,
    mc_mem_responder_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = LATENCY[3:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q;
    logic [2:0]    func3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array wrap and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    // Transaction being completed. With LATENCY=0 the response is built on the accepting
    // edge, so the attributes come straight from the bus while IDLE.
    logic          cur_write;
    logic [2:0]    cur_func3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;

    always_comb begin
        if (state_q == IDLE) begin
            cur_write = bus.req_write;
            cur_func3 = bus.req_func3;
            cur_addr  = bus.req_addr[AW+1:0];
            cur_wdata = bus.req_wdata;
        end else begin
            cur_write = write_q;
            cur_func3 = func3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_word;
    assign cur_idx  = cur_addr[AW+1:2];
    assign cur_word = mem[cur_idx];

    // Illegal widths (011, 11x) and unsigned widths on stores, plus misalignment.
    logic cur_err;
    always_comb begin
        cur_err = 1'b0;
        case (cur_func3)
            3'b000:  cur_err = 1'b0;
            3'b001:  cur_err = cur_addr[0];
            3'b010:  cur_err = |cur_addr[1:0];
            3'b100:  cur_err = cur_write;
            3'b101:  cur_err = cur_write | cur_addr[0];
            default: cur_err = 1'b1;
        endcase
    end

    // Load lane selection and extension.
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    always_comb begin
        byte_val = 8'h00;
        case (cur_addr[1:0])
            2'd0: byte_val = cur_word[7:0];
            2'd1: byte_val = cur_word[15:8];
            2'd2: byte_val = cur_word[23:16];
            2'd3: byte_val = cur_word[31:24];
            default: byte_val = 8'h00;
        endcase
        half_val = cur_addr[1] ? cur_word[31:16] : cur_word[15:0];
        load_val = 32'h0;
        case (cur_func3)
            3'b000:  load_val = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_val = {{16{half_val[15]}}, half_val};
            3'b010:  load_val = cur_word;
            3'b100:  load_val = {24'h0, byte_val};
            3'b101:  load_val = {16'h0, half_val};
            default: load_val = 32'h0;
        endcase
    end

    // Store byte enables and lane-replicated data.
    logic [3:0]  st_be;
    logic [31:0] st_data;
    always_comb begin
        st_be   = 4'b0000;
        st_data = cur_wdata;
        case (cur_func3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << cur_addr[1:0];
                st_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                st_be   = 4'b1111;
                st_data = cur_wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = cur_wdata;
            end
        endcase
    end

    logic enter_resp;
    logic commit;
    assign enter_resp = ((state_q == IDLE) && bus.req_valid && (LAT == 4'd0)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));
    // Gate with reset so a request held during reset cannot write the array.
    assign commit     = enter_resp && cur_write && !cur_err && reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (!cur_write && !cur_err) ? load_val : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && bus.req_valid) begin
                write_q <= bus.req_write;
                func3_q <= bus.req_func3;
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Array has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: one LATENCY=2 instance (functional and timing vectors) and one
// LATENCY=0 instance (back-to-back throughput). Expected responses go into per-instance
// queues; monitors pop and compare whenever resp_valid is seen.
module tb_mc_mem_responder;
    localparam int unsigned LAT_A = 2;

    logic clk;
    logic reset;

    mc_mem_responder_if bus_a ();
    mc_mem_responder_if bus_b ();

    mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [32:0] q_a [$];
    logic [32:0] q_b [$];
    logic [32:0] exp_a, exp_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: {err, rdata} per response.
    always @(negedge clk) begin
        if (bus_a.resp_valid) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_resp got=resp_valid exp=no_response");
            end else begin
                exp_a = q_a.pop_front();
                check("a_resp_err", {31'h0, bus_a.resp_err}, {31'h0, exp_a[32]});
                check("a_resp_rdata", bus_a.resp_rdata, exp_a[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.resp_valid) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_resp got=resp_valid exp=no_response");
            end else begin
                exp_b = q_b.pop_front();
                check("b_resp_err", {31'h0, bus_b.resp_err}, {31'h0, exp_b[32]});
                check("b_resp_rdata", bus_b.resp_rdata, exp_b[31:0]);
            end
        end
    end

    // One transaction on instance A, with latency and busy-window checks.
    task automatic do_a(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
        int  n;
        int  nb;
        logic got;
        @(negedge clk);
        check("a_ready_idle", {31'h0, bus_a.req_ready}, 32'd1);
        bus_a.req_valid = 1'b1;
        bus_a.req_write = w;
        bus_a.req_func3 = f3;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wdata;
        q_a.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1 bus_a.req_valid = 1'b0;
        n   = 0;
        nb  = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus_a.busy) nb++;
            if (bus_a.resp_valid) got = 1'b1;
        end
        check("a_latency", n, LAT_A + 1);
        check("a_busy_cycles", nb, LAT_A + 1);
    endtask

    int acc;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.req_valid = 1'b0;
        bus_a.req_write = 1'b0;
        bus_a.req_func3 = 3'b010;
        bus_a.req_addr  = 32'h0;
        bus_a.req_wdata = 32'h0;
        bus_b.req_valid = 1'b0;
        bus_b.req_write = 1'b0;
        bus_b.req_func3 = 3'b010;
        bus_b.req_addr  = 32'h0;
        bus_b.req_wdata = 32'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, bus_a.req_ready}, 32'd1);
        check("rst_busy", {31'h0, bus_a.busy}, 32'd0);
        check("rst_resp_valid", {31'h0, bus_a.resp_valid}, 32'd0);
        check("rst_rdata", bus_a.resp_rdata, 32'h0);
        reset = 1'b1;

        // Store then sub-word loads.
        do_a(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_a(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        do_a(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_a(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        do_a(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        do_a(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        do_a(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);

        // Byte/half lane stores.
        do_a(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
        do_a(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        do_a(1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
        do_a(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);

        // Errors: misaligned, illegal func3; no array side effects.
        do_a(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
        do_a(1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_a(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_a(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_a(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
        do_a(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
        // Address wrap modulo 4 KiB.
        do_a(1'b0, 3'b010, 32'h1010, 32'h0, 32'h123455EF, 1'b0);

        // Store aborted by reset during WAIT is lost.
        do_a(1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_write = 1'b1;
        bus_a.req_func3 = 3'b010;
        bus_a.req_addr  = 32'h20;
        bus_a.req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 bus_a.req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_in_wait", {31'h0, bus_a.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_ready", {31'h0, bus_a.req_ready}, 32'd1);
        check("abort_busy", {31'h0, bus_a.busy}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", {31'h0, bus_a.resp_valid}, 32'd0);
        end
        reset = 1'b1;
        do_a(1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);

        // LATENCY=0 instance: response the cycle after acceptance.
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b1;
        bus_b.req_func3 = 3'b010;
        bus_b.req_addr  = 32'h40;
        bus_b.req_wdata = 32'hCAFEF00D;
        q_b.push_back({1'b0, 32'h0});
        @(posedge clk);
        #1 bus_b.req_valid = 1'b0;
        @(negedge clk);
        check("b_lat0_resp", {31'h0, bus_b.resp_valid}, 32'd1);

        // Held req_valid: one acceptance every two cycles, none during RESP.
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b0;
        bus_b.req_func3 = 3'b010;
        bus_b.req_addr  = 32'h40;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus_b.req_ready) begin
                acc++;
                q_b.push_back({1'b0, 32'hCAFEF00D});
            end else begin
                check("b_not_ready_only_in_resp", {31'h0, bus_b.resp_valid}, 32'd1);
            end
            @(negedge clk);
        end
        bus_b.req_valid = 1'b0;
        check("b_acceptances", acc, 32'd4);

        repeat (4) @(negedge clk);
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
